rr_priority_arbiter: RTL

Sequential arbiter for N requesters. It turns the combinational highest-bit-wins priority function into a registered request/grant handshake. Modes are fixed priority (highest index wins) or round-robin with a rotating priority pointer, plus a hold-time watchdog. It sits between the priority circuit lab blocks and shared-resource users, and is driven by the same vector-file benches.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_priority_arbiter_if.sv | 24 ++
 rtl/prio_sel.sv | 22 ++
 rtl/rr_priority_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and helpers for the round-robin priority arbiter
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Sized for the largest supported requester count; callers truncate to their index width.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// rtl/rr_priority_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_priority_arbiter_if import arb_pkg::*; #(
  parameter int N = N_DEF
);
  localparam int IW = $clog2(N);

  logic          rr_mode;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  modport master (
    output rr_mode, req,
    input  grant, grant_valid, grant_idx, timeout
  );

  modport slave (
    input  rr_mode, req,
    output grant, grant_valid, grant_idx, timeout
  );

endinterface

// File: rtl/prio_sel.sv
// rtl/prio_sel.sv - combinational highest-set-bit one-hot selector, zero in gives zero out
module prio_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] sel
);

  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - registered fixed/round-robin arbiter with hold-time watchdog
module rr_priority_arbiter import arb_pkg::*; #(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic                  clk,
  input logic                  reset,
  rr_priority_arbiter_if.slave bus
);

  localparam int            IW  = $clog2(N);
  localparam int            HW  = $clog2(MAX_HOLD + 1);
  localparam logic [IW:0]   N_W = (IW + 1)'(N);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0]  mask;

  logic [N-1:0]  grant_q;
  logic          valid_q;
  logic [IW-1:0] idx_q;
  logic          timeout_q;

  logic [N-1:0]   elig, rot, rot_sel, sel;
  logic [2*N-1:0] elig2, sel2;
  logic [IW:0]    sh, unsh;
  logic [15:0]    sel16;
  logic [IW-1:0]  sel_idx;

  // Rotating right by ptr+1 puts requester ptr at the MSB, so the plain
  // highest-bit selector searches ptr, ptr-1, ..., wrapping to ptr+1.
  always_comb begin
    elig = bus.req & ~mask;
    sh   = '0;
    if (bus.rr_mode && ptr != IW'(N - 1))
      sh = {1'b0, ptr} + {{IW{1'b0}}, 1'b1};
    unsh  = N_W - sh;
    elig2 = {elig, elig};
    rot   = elig2[sh +: N];
  end

  prio_sel #(.N(N)) u_sel (
    .vec (rot),
    .sel (rot_sel)
  );

  always_comb begin
    sel2           = {rot_sel, rot_sel};
    sel            = sel2[unsh +: N];
    sel16          = '0;
    sel16[N-1:0]   = sel;
    sel_idx        = IW'(onehot_to_idx(sel16));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(N - 1);
      hold_cnt  <= '0;
      mask      <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      mask      <= mask & bus.req;
      case (state)
        IDLE: begin
          if (|elig) begin
            grant_q  <= sel;
            valid_q  <= 1'b1;
            idx_q    <= sel_idx;
            hold_cnt <= HW'(1);
            state    <= GRANT;
            if (bus.rr_mode)
              ptr <= (sel_idx == '0) ? IW'(N - 1) : sel_idx - IW'(1);
          end
        end
        GRANT: begin
          // Release takes precedence over the watchdog on the same edge.
          if (!bus.req[idx_q]) begin
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            hold_cnt <= '0;
            state    <= IDLE;
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            grant_q     <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            hold_cnt    <= '0;
            timeout_q   <= 1'b1;
            mask[idx_q] <= 1'b1;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
  assign bus.timeout     = timeout_q;

endmodule
